fp_sqrt_requester: RTL and testbench

- Initiator side of the floating-point square-root engine's start/done protocol.
- Accepts single-precision operands from an upstream valid/ready producer and latches each one.
- Pulses start to the sqrt engine, waits for done with a watchdog, captures the result and flags, and presents them on a downstream valid/ready port.
- Sits between the system bus adapter and the sqrt controller/datapath.

---
 rtl/fpsqrt_pkg.sv | 32 +++
 rtl/fp_sqrt_requester_if.sv | 36 +++
 rtl/fpsqrt_watchdog.sv | 36 +++
 rtl/fp_sqrt_requester.sv | 126 ++++++++++++
 tb/tb_fp_sqrt_requester.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fpsqrt_pkg.sv
// Shared definitions for the floating-point square-root requester:
// FSM encoding, IEEE-754 single field widths, canonical quiet NaN and operand classifiers.
package fpsqrt_pkg;

    localparam int SIGN_W         = 1;
    localparam int EXP_W          = 8;
    localparam int FRAC_W         = 23;
    localparam int FP_W           = SIGN_W + EXP_W + FRAC_W;
    localparam int ENGINE_LATENCY = 47;

    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    function automatic logic fp_is_zero(input logic [FP_W-1:0] x);
        return x[FP_W-2:0] == '0;
    endfunction

    function automatic logic fp_is_nan(input logic [FP_W-1:0] x);
        return (x[FP_W-2 -: EXP_W] == '1) && (x[FRAC_W-1:0] != '0);
    endfunction

    function automatic logic fp_is_pos_inf(input logic [FP_W-1:0] x);
        return x == {1'b0, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    endfunction

endpackage

// File: rtl/fp_sqrt_requester_if.sv
// Bundles the upstream operand port, the sqrt engine start/done port and the downstream result port.
// master = requester side, slave = the surrounding producer/engine/consumer.
interface fp_sqrt_requester_if #(
    parameter int DATA_W = 32
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    logic              sqrt_start;
    logic [DATA_W-1:0] sqrt_operand;
    logic              sqrt_done;
    logic [DATA_W-1:0] sqrt_result;
    logic              sqrt_negative;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_invalid;
    logic              out_timeout;
    logic              err_spurious;

    modport master (
        input  in_valid, in_data, sqrt_done, sqrt_result, sqrt_negative, out_ready,
        output in_ready, sqrt_start, sqrt_operand, out_valid, out_data,
               out_invalid, out_timeout, err_spurious
    );

    modport slave (
        output in_valid, in_data, sqrt_done, sqrt_result, sqrt_negative, out_ready,
        input  in_ready, sqrt_start, sqrt_operand, out_valid, out_data,
               out_invalid, out_timeout, err_spurious
    );

endinterface

// File: rtl/fpsqrt_watchdog.sv
// Cycle counter bounding how long the requester waits for the sqrt engine.
// expired is asserted while the count sits at TIMEOUT_CYCLES-1.
module fpsqrt_watchdog #(
    parameter int TIMEOUT_CYCLES = 63,
    parameter int CNT_W          = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fp_sqrt_requester.sv
// Initiator for the sqrt engine start/done protocol: latch operand, pulse start, wait with watchdog, hold result.
// Optional FPSQRT_SPECIAL_BYPASS_EN answers ±0, +Inf, NaN and negative operands without using the engine.
module fp_sqrt_requester
    import fpsqrt_pkg::*;
#(
    parameter int              DATA_W         = 32,
    parameter int              TIMEOUT_CYCLES = 63,
    parameter int              CNT_W          = 6,
    parameter logic [DATA_W-1:0] QNAN         = FP_QNAN
) (
    input logic                 clk,
    input logic                 rst_n,
    fp_sqrt_requester_if.master bus
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_invalid_q, out_invalid_d;
    logic              out_timeout_q, out_timeout_d;
    logic              err_spurious_q, err_spurious_d;

    logic              wd_clear;
    logic              wd_enable;
    logic              wd_expired;

    fpsqrt_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_comb begin
        state_d        = state_q;
        operand_d      = operand_q;
        out_data_d     = out_data_q;
        out_invalid_d  = out_invalid_q;
        out_timeout_d  = out_timeout_q;
        err_spurious_d = err_spurious_q | (bus.sqrt_done && (state_q != WAIT));
        wd_clear       = 1'b0;
        wd_enable      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    operand_d = bus.in_data;
                    state_d   = ISSUE;
`ifdef FPSQRT_SPECIAL_BYPASS_EN
                    if (fp_is_zero(bus.in_data) || fp_is_pos_inf(bus.in_data)) begin
                        out_data_d    = bus.in_data;
                        out_invalid_d = 1'b0;
                        out_timeout_d = 1'b0;
                        state_d       = HOLD;
                    end else if (fp_is_nan(bus.in_data) || bus.in_data[DATA_W-1]) begin
                        out_data_d    = QNAN;
                        out_invalid_d = 1'b1;
                        out_timeout_d = 1'b0;
                        state_d       = HOLD;
                    end
`endif
                end
            end
            ISSUE: begin
                wd_clear = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                wd_enable = 1'b1;
                // A done landing on the expiry cycle still counts as a normal completion
                if (bus.sqrt_done) begin
                    out_data_d    = bus.sqrt_negative ? QNAN : bus.sqrt_result;
                    out_invalid_d = bus.sqrt_negative;
                    out_timeout_d = 1'b0;
                    state_d       = HOLD;
                end else if (wd_expired) begin
                    out_data_d    = QNAN;
                    out_invalid_d = 1'b1;
                    out_timeout_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            operand_q      <= '0;
            out_data_q     <= '0;
            out_invalid_q  <= 1'b0;
            out_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            operand_q      <= operand_d;
            out_data_q     <= out_data_d;
            out_invalid_q  <= out_invalid_d;
            out_timeout_q  <= out_timeout_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    // in_ready is gated by rst_n so that every output reads 0 while reset is held
    assign bus.in_ready     = rst_n && (state_q == IDLE);
    assign bus.sqrt_start   = (state_q == ISSUE);
    assign bus.out_valid    = (state_q == HOLD);
    assign bus.sqrt_operand = operand_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_invalid  = out_invalid_q;
    assign bus.out_timeout  = out_timeout_q;
    assign bus.err_spurious = err_spurious_q;

endmodule

// File: tb/tb_fp_sqrt_requester.sv
// Directed bench for fp_sqrt_requester: vector table through a behavioural engine plus
// hand sequences for HOLD stall, spurious done, mid-WAIT reset and (optionally) special bypass.
module tb_fp_sqrt_requester;
    import fpsqrt_pkg::*;

    localparam int DATA_W = 32;
    localparam logic [31:0] QNAN_EXP = 32'h7FC0_0000;
`ifdef FPSQRT_SPECIAL_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [31:0] operand;
        int          delay;
        logic [31:0] result;
        logic        negative;
        logic [31:0] exp_data;
        logic        exp_invalid;
        logic        exp_timeout;
        int          exp_latency;
        int          exp_starts;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    always #5 clk = ~clk;

    fp_sqrt_requester_if #(.DATA_W(DATA_W)) bus ();

    fp_sqrt_requester #(
        .DATA_W        (DATA_W),
        .TIMEOUT_CYCLES(63),
        .CNT_W         (6),
        .QNAN          (32'h7FC0_0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Hands one operand over, plays the engine (done after v.delay cycles, never if negative delay)
    // and returns the number of cycles from acceptance to out_valid plus the start pulses seen.
    task automatic applyStimulus(input vec_t v, output int latency, output int starts);
        latency = -1;
        starts  = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = v.operand;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (bus.sqrt_start) starts++;
            if (bus.out_valid) begin
                latency = cyc;
                break;
            end
            bus.sqrt_done     = (v.delay >= 0) && (cyc == 1 + v.delay);
            bus.sqrt_result   = bus.sqrt_done ? v.result : 32'h0;
            bus.sqrt_negative = bus.sqrt_done && v.negative;
            @(negedge clk);
        end
        bus.sqrt_done     = 1'b0;
        bus.sqrt_result   = 32'h0;
        bus.sqrt_negative = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input vec_t v);
        int latency;
        int starts;
        applyStimulus(v, latency, starts);
        checkOutput({tag, " latency"}, latency, v.exp_latency);
        checkOutput({tag, " starts"}, starts, v.exp_starts);
        checkOutput({tag, " out_data"}, bus.out_data, v.exp_data);
        checkOutput({tag, " out_invalid"}, 32'(bus.out_invalid), 32'(v.exp_invalid));
        checkOutput({tag, " out_timeout"}, 32'(bus.out_timeout), 32'(v.exp_timeout));
        checkOutput({tag, " sqrt_operand"}, bus.sqrt_operand, v.operand);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({tag, " out_valid after handshake"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, " in_ready after handshake"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
        checkOutput({tag, " sqrt_start"}, 32'(bus.sqrt_start), 32'd0);
        checkOutput({tag, " sqrt_operand"}, bus.sqrt_operand, 32'd0);
        checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, " out_data"}, bus.out_data, 32'd0);
        checkOutput({tag, " out_invalid"}, 32'(bus.out_invalid), 32'd0);
        checkOutput({tag, " out_timeout"}, 32'(bus.out_timeout), 32'd0);
        checkOutput({tag, " err_spurious"}, 32'(bus.err_spurious), 32'd0);
    endtask

    initial begin
        vec_t vecs[6];
        vec_t v;
        int   starts;
        int   outs;

        bus.in_valid      = 1'b0;
        bus.in_data       = 32'h0;
        bus.sqrt_done     = 1'b0;
        bus.sqrt_result   = 32'h0;
        bus.sqrt_negative = 1'b0;
        bus.out_ready     = 1'b0;

        vecs[0] = '{32'h4080_0000, ENGINE_LATENCY, 32'h4000_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 49, 1};
        vecs[1] = BYPASS ?
                  '{32'hC080_0000, ENGINE_LATENCY, 32'h1234_5678, 1'b1, QNAN_EXP, 1'b1, 1'b0, 1, 0} :
                  '{32'hC080_0000, ENGINE_LATENCY, 32'h1234_5678, 1'b1, QNAN_EXP, 1'b1, 1'b0, 49, 1};
        vecs[2] = '{32'h4110_0000, -1, 32'h0, 1'b0, QNAN_EXP, 1'b1, 1'b1, 65, 1};
        vecs[3] = '{32'h4110_0000, 63, 32'h4040_0000, 1'b0, 32'h4040_0000, 1'b0, 1'b0, 65, 1};
        vecs[4] = '{32'h3F80_0000, 1, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0, 3, 1};
        vecs[5] = '{32'h41C8_0000, 10, 32'h40A0_0000, 1'b0, 32'h40A0_0000, 1'b0, 1'b0, 12, 1};

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i]);
        end
        checkOutput("no spurious after table", 32'(bus.err_spurious), 32'd0);

        // HOLD stall with a competing operand offered upstream
        v = '{32'h4080_0000, 5, 32'h4000_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 7, 1};
        applyStimulus(v, outs, starts);
        checkOutput("stall latency", outs, 7);
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hDEAD_BEEF;
            @(negedge clk);
            checkOutput($sformatf("stall%0d out_valid", k), 32'(bus.out_valid), 32'd1);
            checkOutput($sformatf("stall%0d in_ready", k), 32'(bus.in_ready), 32'd0);
            checkOutput($sformatf("stall%0d out_data", k), bus.out_data, 32'h4000_0000);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("stall release in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("stall operand kept", bus.sqrt_operand, 32'h4080_0000);

        // Spurious done in IDLE is sticky across later transactions
        bus.sqrt_done = 1'b1;
        @(negedge clk);
        bus.sqrt_done = 1'b0;
        checkOutput("spurious set", 32'(bus.err_spurious), 32'd1);
        checkOutput("spurious no start", 32'(bus.sqrt_start), 32'd0);
        run_and_check("post-spurious", vecs[5]);
        checkOutput("spurious sticky", 32'(bus.err_spurious), 32'd1);

        // Reset during WAIT abandons the operation without reissuing start
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h4110_0000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid-wait reset");
        @(negedge clk);
        rst_n  = 1'b1;
        starts = 0;
        outs   = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus.sqrt_start) starts++;
            if (bus.out_valid) outs++;
        end
        checkOutput("post-reset starts", starts, 0);
        checkOutput("post-reset out_valid", outs, 0);
        checkOutput("post-reset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("post-reset err_spurious", 32'(bus.err_spurious), 32'd0);

`ifdef FPSQRT_SPECIAL_BYPASS_EN
        run_and_check("bypass +inf", '{32'h7F80_0000, -1, 32'h0, 1'b0, 32'h7F80_0000, 1'b0, 1'b0, 1, 0});
        run_and_check("bypass -0", '{32'h8000_0000, -1, 32'h0, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1, 0});
        run_and_check("bypass nan", '{32'h7FC0_0001, -1, 32'h0, 1'b0, QNAN_EXP, 1'b1, 1'b0, 1, 0});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
